// File: rtl/cv32e40x_xif_pkg.sv
// rtl/cv32e40x_xif_pkg.sv - X-IF memory and result channel types shared with the core
package cv32e40x_xif_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    logic                  we;
    logic [2:0]            size;
    logic [3:0]            be;
    logic [1:0]            attr;
    logic [31:0]           wdata;
    logic                  last;
    logic                  spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           rdata;
    logic                  err;
    logic                  dbg;
  } x_mem_result_t;

endpackage

// File: rtl/vmem_arbiter_pkg.sv
// rtl/vmem_arbiter_pkg.sv - requester index type and default sizing for the VLSU memory arbiter
package vmem_arbiter_pkg;

  localparam int unsigned NUM_REQ_MAX             = 4;
  localparam int unsigned NUM_REQ_DEFAULT         = 2;
  localparam int unsigned X_ID_WIDTH_DEFAULT      = 4;
  localparam int unsigned MAX_OUTSTANDING_DEFAULT = 4;

  typedef logic [1:0] req_idx_t;

  // Round-robin successor of g among n requesters.
  function automatic req_idx_t rr_next(input req_idx_t g, input int unsigned n);
    logic [2:0] sum;
    sum = {1'b0, g} + 3'd1;
    if (sum >= 3'(n)) return '0;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/vmem_arb_tracker.sv
// rtl/vmem_arb_tracker.sv - in-order FIFO of granted requester indices awaiting a result
module vmem_arb_tracker
  import vmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTSTANDING_DEFAULT
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  req_idx_t push_idx_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output req_idx_t head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  req_idx_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Fullness is judged before any same-cycle pop, so a full tracker never takes a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_idx_i;
  end

endmodule

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - round-robin arbiter of VLSU requesters onto one X-IF memory channel
// Optional burst lock (grant held until req.last) with VMEM_ARBITER_LOCK_EN defined.
module vmem_arbiter
  import cv32e40x_xif_pkg::*;
  import vmem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEFAULT,
  parameter int unsigned X_ID_WIDTH      = X_ID_WIDTH_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  x_mem_req_t [NUM_REQ-1:0]     req_i,
  output x_mem_resp_t [NUM_REQ-1:0]    resp_o,
  output logic [NUM_REQ-1:0]           result_valid_o,
  output x_mem_result_t                result_o,
  output logic                         xif_mem_valid_o,
  input  logic                         xif_mem_ready_i,
  output x_mem_req_t                   xif_mem_req_o,
  input  x_mem_resp_t                  xif_mem_resp_i,
  input  logic                         xif_mem_result_valid_i,
  input  x_mem_result_t                xif_mem_result_i,
  output logic                         spurious_o
);

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("vmem_arbiter: NUM_REQ must be 2..4");
  end
  if (X_ID_WIDTH != cv32e40x_xif_pkg::X_ID_WIDTH) begin : g_bad_id_width
    $error("vmem_arbiter: X_ID_WIDTH must match the X-IF package");
  end

  req_idx_t   gnt_q, gnt_d;
  req_idx_t   rr_ptr_q, rr_ptr_d;
  logic       hold_q, hold_d;
  logic       spurious_q, spurious_d;
  logic       burst_lock;

  req_idx_t   pick, gnt;
  logic       found, use_held, gnt_valid, mem_valid, accept;
  logic [2:0] sum;
  x_mem_req_t req_sel;

  logic       trk_full, trk_empty, trk_pop;
  req_idx_t   trk_head;

  // Round-robin search starting at the pointer; the first valid requester wins.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + 3'(i);
      if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && sum[1:0] == req_idx_t'(j) && req_valid_i[j]) begin
          pick  = req_idx_t'(j);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    use_held  = hold_q | burst_lock;
    gnt       = use_held ? gnt_q : pick;
    gnt_valid = 1'b0;
    req_sel   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt == req_idx_t'(j)) begin
        gnt_valid = req_valid_i[j];
        req_sel   = req_i[j];
      end
    end
    mem_valid = ~rst_i & ~trk_full & (use_held ? gnt_valid : found);
    accept    = mem_valid & xif_mem_ready_i;

    hold_d   = mem_valid & ~xif_mem_ready_i;
    gnt_d    = gnt;
    rr_ptr_d = accept ? rr_next(gnt, NUM_REQ) : rr_ptr_q;
  end

  assign xif_mem_valid_o = mem_valid;
  assign xif_mem_req_o   = req_sel;
  assign result_o        = xif_mem_result_i;

  always_comb begin
    req_ready_o    = '0;
    resp_o         = '0;
    result_valid_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt == req_idx_t'(j)) begin
        req_ready_o[j] = accept;
        if (mem_valid) resp_o[j] = xif_mem_resp_i;
      end
      if (trk_head == req_idx_t'(j)) result_valid_o[j] = trk_pop;
    end
  end

  // A result with nothing outstanding is dropped and flagged until reset.
  assign trk_pop    = ~rst_i & xif_mem_result_valid_i & ~trk_empty;
  assign spurious_d = spurious_q | (xif_mem_result_valid_i & trk_empty);
  assign spurious_o = spurious_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      spurious_q <= spurious_d;
    end
  end

`ifdef VMEM_ARBITER_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_d = lock_q;
    if (accept) lock_d = ~req_sel.last;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  assign burst_lock = lock_q;
`else
  assign burst_lock = 1'b0;
`endif

  vmem_arb_tracker #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_idx_i (gnt),
    .pop_i      (trk_pop),
    .full_o     (trk_full),
    .empty_o    (trk_empty),
    .head_o     (trk_head)
  );

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb/tb_vmem_arbiter.sv - directed vector bench for vmem_arbiter
module tb_vmem_arbiter;
  import cv32e40x_xif_pkg::*;

  localparam int NR = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NR-1:0]          req_valid_i;
  logic [NR-1:0]          req_ready_o;
  x_mem_req_t [NR-1:0]    req_i;
  x_mem_resp_t [NR-1:0]   resp_o;
  logic [NR-1:0]          result_valid_o;
  x_mem_result_t          result_o;
  logic                   xif_mem_valid_o;
  logic                   xif_mem_ready_i;
  x_mem_req_t             xif_mem_req_o;
  x_mem_resp_t            xif_mem_resp_i;
  logic                   xif_mem_result_valid_i;
  x_mem_result_t          xif_mem_result_i;
  logic                   spurious_o;

  vmem_arbiter #(.NUM_REQ(NR), .X_ID_WIDTH(4), .MAX_OUTSTANDING(4)) u_dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .req_valid_i            (req_valid_i),
    .req_ready_o            (req_ready_o),
    .req_i                  (req_i),
    .resp_o                 (resp_o),
    .result_valid_o         (result_valid_o),
    .result_o               (result_o),
    .xif_mem_valid_o        (xif_mem_valid_o),
    .xif_mem_ready_i        (xif_mem_ready_i),
    .xif_mem_req_o          (xif_mem_req_o),
    .xif_mem_resp_i         (xif_mem_resp_i),
    .xif_mem_result_valid_i (xif_mem_result_valid_i),
    .xif_mem_result_i       (xif_mem_result_i),
    .spurious_o             (spurious_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] vld;
    logic       rdy;
    logic       rv;
    logic       e_mv;
    logic       e_gnt;
    logic [1:0] e_rr;
    logic [1:0] e_rv;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [1:0] vld, logic rdy, logic rv, logic e_mv,
                              logic e_gnt, logic [1:0] e_rr, logic [1:0] e_rv);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.rv = rv; v.e_mv = e_mv;
    v.e_gnt = e_gnt; v.e_rr = e_rr; v.e_rv = e_rv;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input logic g);
    return g ? 32'h0000_2000 : 32'h0000_1000;
  endfunction

  x_mem_resp_t          resp_c;
  x_mem_resp_t [NR-1:0] er;
  int                   beats0;
  logic                 exp_g;

  initial begin
    req_valid_i            = '0;
    xif_mem_ready_i        = 1'b0;
    xif_mem_result_valid_i = 1'b0;
    xif_mem_result_i       = '0;
    resp_c                 = '0;
    resp_c.exc             = 1'b1;
    resp_c.exccode         = 6'h0d;
    xif_mem_resp_i         = resp_c;
    req_i                  = '0;
    req_i[0].addr          = 32'h0000_1000;
    req_i[0].last          = 1'b1;
    req_i[1].addr          = 32'h0000_2000;
    req_i[1].last          = 1'b1;

    // round robin, push+pop, stall hold, full tracker, drain
    vt.push_back(mk(2'b11, 1, 0, 1, 0, 2'b01, 2'b00));
    vt.push_back(mk(2'b11, 1, 1, 1, 1, 2'b10, 2'b01));
    vt.push_back(mk(2'b11, 1, 1, 1, 0, 2'b01, 2'b10));
    vt.push_back(mk(2'b11, 1, 1, 1, 1, 2'b10, 2'b01));
    vt.push_back(mk(2'b00, 1, 1, 0, 0, 2'b00, 2'b10));
    vt.push_back(mk(2'b10, 0, 0, 1, 1, 2'b00, 2'b00));
    vt.push_back(mk(2'b11, 0, 0, 1, 1, 2'b00, 2'b00));
    vt.push_back(mk(2'b11, 0, 0, 1, 1, 2'b00, 2'b00));
    vt.push_back(mk(2'b11, 1, 0, 1, 1, 2'b10, 2'b00));
    vt.push_back(mk(2'b11, 1, 0, 1, 0, 2'b01, 2'b00));
    vt.push_back(mk(2'b11, 1, 0, 1, 1, 2'b10, 2'b00));
    vt.push_back(mk(2'b11, 1, 0, 1, 0, 2'b01, 2'b00));
    vt.push_back(mk(2'b11, 1, 0, 0, 0, 2'b00, 2'b00));
    vt.push_back(mk(2'b11, 1, 1, 0, 0, 2'b00, 2'b10));
    vt.push_back(mk(2'b11, 1, 0, 1, 1, 2'b10, 2'b00));
    vt.push_back(mk(2'b11, 1, 0, 0, 0, 2'b00, 2'b00));
    vt.push_back(mk(2'b00, 1, 1, 0, 0, 2'b00, 2'b01));
    vt.push_back(mk(2'b00, 1, 1, 0, 0, 2'b00, 2'b10));
    vt.push_back(mk(2'b00, 1, 1, 0, 0, 2'b00, 2'b01));
    vt.push_back(mk(2'b00, 1, 1, 0, 0, 2'b00, 2'b10));
    vt.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00));

    // reset state, with inputs active
    #1 rst = 1'b1;
    req_valid_i            = 2'b11;
    xif_mem_ready_i        = 1'b1;
    xif_mem_result_valid_i = 1'b1;
    #2;
    chk("rst_mem_valid", 64'(xif_mem_valid_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_result_valid", 64'(result_valid_o), 64'd0);
    chk("rst_spurious", 64'(spurious_o), 64'd0);
    step();
    step();
    req_valid_i            = '0;
    xif_mem_ready_i        = 1'b0;
    xif_mem_result_valid_i = 1'b0;
    rst = 1'b0;

    foreach (vt[k]) begin
      req_valid_i            = vt[k].vld;
      xif_mem_ready_i        = vt[k].rdy;
      xif_mem_result_valid_i = vt[k].rv;
      #2;
      chk($sformatf("v%0d_mem_valid", k), 64'(xif_mem_valid_o), 64'(vt[k].e_mv));
      chk($sformatf("v%0d_req_ready", k), 64'(req_ready_o), 64'(vt[k].e_rr));
      chk($sformatf("v%0d_result_valid", k), 64'(result_valid_o), 64'(vt[k].e_rv));
      chk($sformatf("v%0d_spurious", k), 64'(spurious_o), 64'd0);
      if (vt[k].e_mv) begin
        er = '0;
        er[vt[k].e_gnt] = resp_c;
        chk($sformatf("v%0d_addr", k), 64'(xif_mem_req_o.addr), 64'(addr_of(vt[k].e_gnt)));
        chk($sformatf("v%0d_resp", k), 64'(resp_o), 64'(er));
      end
      step();
    end

    // result with nothing outstanding
    req_valid_i            = '0;
    xif_mem_result_valid_i = 1'b1;
    #2;
    chk("spur_result_valid", 64'(result_valid_o), 64'd0);
    step();
    xif_mem_result_valid_i = 1'b0;
    chk("spur_set", 64'(spurious_o), 64'd1);
    step(); step(); step();
    chk("spur_sticky", 64'(spurious_o), 64'd1);

    // reset with two outstanding, then a late result
    req_valid_i     = 2'b01;
    xif_mem_ready_i = 1'b1;
    #2;
    chk("pre_rst_acc0", 64'(req_ready_o), 64'b01);
    step();
    chk("pre_rst_acc1", 64'(req_ready_o), 64'b01);
    step();
    rst         = 1'b1;
    req_valid_i = 2'b11;
    #2;
    chk("midrst_mem_valid", 64'(xif_mem_valid_o), 64'd0);
    chk("midrst_spurious", 64'(spurious_o), 64'd0);
    step();
    rst             = 1'b0;
    xif_mem_ready_i = 1'b0;
    #2;
    chk("postrst_mem_valid", 64'(xif_mem_valid_o), 64'd1);
    chk("postrst_rr_ptr", 64'(xif_mem_req_o.addr), 64'(addr_of(1'b0)));
    step();
    req_valid_i            = 2'b00;
    xif_mem_result_valid_i = 1'b1;
    #2;
    chk("postrst_result_valid", 64'(result_valid_o), 64'd0);
    step();
    xif_mem_result_valid_i = 1'b0;
    chk("postrst_spurious", 64'(spurious_o), 64'd1);

    // 8-beat burst from req0 with req1 contending
    rst = 1'b1;
    step();
    rst             = 1'b0;
    beats0          = 0;
    req_valid_i     = 2'b11;
    xif_mem_ready_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      req_i[0].last          = (beats0 == 7);
      xif_mem_result_valid_i = (c > 0);
`ifdef VMEM_ARBITER_LOCK_EN
      exp_g = (c >= 8);
`else
      exp_g = c[0];
`endif
      #2;
      chk($sformatf("burst%0d_mem_valid", c), 64'(xif_mem_valid_o), 64'd1);
      chk($sformatf("burst%0d_addr", c), 64'(xif_mem_req_o.addr), 64'(addr_of(exp_g)));
      if (req_ready_o[0]) beats0++;
      step();
    end
    req_valid_i            = '0;
    xif_mem_result_valid_i = 1'b0;
    chk("burst_spurious", 64'(spurious_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
